// File: rtl/tag_alloc_freelist.sv
// Rename-side tag allocator: circular free list of tags, in-order
// multi-port grant, tagfile write drive, retire push and flush refill.
module tag_alloc_freelist #(
    parameter int ports  = 2,
    parameter int addr_w = 5,
    parameter int tag_w  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [ports-1:0]        alloc_req,
    input  logic [ports*addr_w-1:0] alloc_rd,
    output logic [ports-1:0]        alloc_gnt,
    output logic [ports*tag_w-1:0]  alloc_tag,
    input  logic [ports-1:0]        ret_valid,
    input  logic [ports*tag_w-1:0]  ret_tag,
    output logic [ports-1:0]        tf_wr_en,
    output logic [ports*addr_w-1:0] tf_wr_addr,
    output logic [ports*tag_w-1:0]  tf_wr_data,
    output logic [tag_w:0]          free_count,
    output logic                    empty,
    output logic                    err
);

    localparam int NT = 2 ** tag_w;
    localparam logic [tag_w:0] NT_C = (tag_w + 1)'(NT);
    localparam logic [tag_w:0] ONE = (tag_w + 1)'(1);

    logic [tag_w-1:0] fifo_q [NT];
    logic [tag_w-1:0] fifo_d [NT];
    logic [tag_w-1:0] head_q, head_d;
    logic [tag_w-1:0] tail_q, tail_d;
    logic [tag_w:0]   count_q, count_d;
    logic             err_q, err_d;

    logic [ports-1:0]       gnt;
    logic [ports-1:0]       wen;
    logic [ports*tag_w-1:0] tag;
    logic [tag_w:0]         nalloc;
    logic [addr_w-1:0]      rd_i;
    logic                   denied;

    // In-order grant: first denied requester blocks all higher ports.
    always_comb begin
        gnt    = '0;
        wen    = '0;
        tag    = '0;
        nalloc = '0;
        denied = 1'b0;
        rd_i   = '0;
        for (int i = 0; i < ports; i++) begin
            rd_i = alloc_rd[i*addr_w +: addr_w];
            if (alloc_req[i]) begin
                if (!rst && !flush && !denied &&
                    (rd_i == '0 || count_q > nalloc)) begin
                    gnt[i] = 1'b1;
                    if (rd_i != '0) begin
                        wen[i] = 1'b1;
                        tag[i*tag_w +: tag_w] =
                            fifo_q[head_q + nalloc[tag_w-1:0]];
                        nalloc = nalloc + ONE;
                    end
                end else begin
                    denied = 1'b1;
                end
            end
        end
    end

    logic [tag_w:0] avail;
    logic [tag_w:0] pushed;
    logic           ovf;

    // Returns land behind the tail; anything beyond capacity is dropped.
    always_comb begin
        fifo_d = fifo_q;
        avail  = NT_C - (count_q - nalloc);
        pushed = '0;
        ovf    = 1'b0;
        for (int i = 0; i < ports; i++) begin
            if (ret_valid[i]) begin
                if (pushed < avail) begin
                    fifo_d[tail_q + pushed[tag_w-1:0]] =
                        ret_tag[i*tag_w +: tag_w];
                    pushed = pushed + ONE;
                end else begin
                    ovf = 1'b1;
                end
            end
        end
        head_d  = head_q + nalloc[tag_w-1:0];
        tail_d  = tail_q + pushed[tag_w-1:0];
        count_d = count_q - nalloc + pushed;
        err_d   = err_q | ovf;
        if (flush) begin
            for (int i = 0; i < NT; i++) begin
                fifo_d[i] = tag_w'(i);
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = NT_C;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                fifo_q[i] <= tag_w'(i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= NT_C;
            err_q   <= 1'b0;
        end else begin
            fifo_q  <= fifo_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign alloc_gnt  = gnt;
    assign alloc_tag  = tag;
    assign tf_wr_en   = wen;
    assign tf_wr_addr = alloc_rd;
    assign tf_wr_data = tag;
    assign free_count = count_q;
    assign empty      = (count_q == '0);
    assign err        = err_q;

endmodule

// File: tb/tb_tag_alloc_freelist.sv
// Randomized bench for tag_alloc_freelist against a queue-based
// free-list model, plus directed literal scenarios.
module tb_tag_alloc_freelist;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [1:0] alloc_req;
    logic [9:0] alloc_rd;
    logic [1:0] alloc_gnt;
    logic [7:0] alloc_tag;
    logic [1:0] ret_valid;
    logic [7:0] ret_tag;
    logic [1:0] tf_wr_en;
    logic [9:0] tf_wr_addr;
    logic [7:0] tf_wr_data;
    logic [4:0] free_count;
    logic       empty;
    logic       err;

    tag_alloc_freelist #(.ports(2), .addr_w(5), .tag_w(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_req(alloc_req), .alloc_rd(alloc_rd),
        .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .ret_valid(ret_valid), .ret_tag(ret_tag),
        .tf_wr_en(tf_wr_en), .tf_wr_addr(tf_wr_addr),
        .tf_wr_data(tf_wr_data), .free_count(free_count),
        .empty(empty), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;
    int q[$];
    bit merr;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic void mreset();
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(i);
    endfunction

    // Free list as a plain queue: grants take from the front in port order.
    function automatic void mgrant(output logic [1:0] g,
                                   output logic [7:0] tg,
                                   output logic [1:0] we,
                                   output int n);
        bit den;
        int rd;
        n = 0; den = 0; g = '0; tg = '0; we = '0;
        for (int i = 0; i < 2; i++) begin
            rd = int'(alloc_rd[i*5 +: 5]);
            if (alloc_req[i]) begin
                if (!flush && !den && (rd == 0 || q.size() > n)) begin
                    g[i] = 1'b1;
                    if (rd != 0) begin
                        tg[i*4 +: 4] = 4'(q[n]);
                        we[i] = 1'b1;
                        n++;
                    end
                end else begin
                    den = 1;
                end
            end
        end
    endfunction

    function automatic void mupdate();
        logic [1:0] g, we;
        logic [7:0] tg;
        int n;
        if (flush) begin
            mreset();
        end else begin
            mgrant(g, tg, we, n);
            repeat (n) void'(q.pop_front());
            for (int i = 0; i < 2; i++) begin
                if (ret_valid[i]) begin
                    if (q.size() < 16) q.push_back(int'(ret_tag[i*4 +: 4]));
                    else merr = 1;
                end
            end
        end
    endfunction

    // Compare on the falling edge, advance the model on the rising edge.
    initial begin
        logic [1:0] eg, ew;
        logic [7:0] et;
        int n;
        forever begin
            @(negedge clk);
            if (rst) begin
                mreset();
                merr = 0;
            end else begin
                mgrant(eg, et, ew, n);
                chk("gnt", int'(alloc_gnt), int'(eg));
                chk("tag", int'(alloc_tag), int'(et));
                chk("wr_en", int'(tf_wr_en), int'(ew));
                chk("wr_addr", int'(tf_wr_addr), int'(alloc_rd));
                chk("wr_data", int'(tf_wr_data), int'(et));
                chk("free_count", int'(free_count), q.size());
                chk("empty", int'(empty), int'(q.size() == 0));
                chk("err", int'(err), int'(merr));
            end
            @(posedge clk);
            if (rst) begin
                mreset();
                merr = 0;
            end else begin
                mupdate();
            end
        end
    end

    task automatic cyc(input logic [1:0] rq, input int r0, input int r1,
                       input logic [1:0] rv, input int t0, input int t1,
                       input logic fl);
        @(posedge clk);
        #1;
        alloc_req = rq;
        alloc_rd  = {5'(r1), 5'(r0)};
        ret_valid = rv;
        ret_tag   = {4'(t1), 4'(t0)};
        flush     = fl;
        #1;
    endtask

    task automatic rnd_drive();
        int room;
        room = 16 - q.size();
        alloc_req = 2'($urandom);
        alloc_rd[4:0] = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        alloc_rd[9:5] = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        flush = ($urandom % 40 == 0);
        ret_valid = 2'($urandom);
        ret_tag = 8'($urandom);
        if (room < 2 && ret_valid[1]) ret_valid[1] = 1'b0;
        if (room < 1) ret_valid = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        alloc_req = '0;
        alloc_rd = '0;
        ret_valid = '0;
        ret_tag = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_count", int'(free_count), 16);
        chk("rst_empty", int'(empty), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_gnt", int'(alloc_gnt), 0);

        cyc(2'b11, 3, 5, 2'b00, 0, 0, 0);
        chk("first_gnt", int'(alloc_gnt), 3);
        chk("first_tag0", int'(alloc_tag[3:0]), 0);
        chk("first_tag1", int'(alloc_tag[7:4]), 1);
        chk("first_wen", int'(tf_wr_en), 3);
        chk("first_waddr", int'(tf_wr_addr), (5 << 5) | 3);
        for (int c = 1; c < 8; c++) begin
            cyc(2'b11, 1 + c, 20 + c, 2'b00, 0, 0, 0);
            chk("seq_count", int'(free_count), 16 - 2 * c);
            chk("seq_tag0", int'(alloc_tag[3:0]), 2 * c);
            chk("seq_tag1", int'(alloc_tag[7:4]), 2 * c + 1);
        end
        cyc(2'b11, 7, 8, 2'b00, 0, 0, 0);
        chk("drain_empty", int'(empty), 1);
        chk("drain_gnt", int'(alloc_gnt), 0);
        chk("drain_wen", int'(tf_wr_en), 0);

        cyc(2'b00, 0, 0, 2'b01, 15, 0, 0);
        cyc(2'b11, 4, 6, 2'b01, 15, 0, 0);
        chk("one_count", int'(free_count), 1);
        chk("one_gnt", int'(alloc_gnt), 1);
        chk("one_tag0", int'(alloc_tag[3:0]), 15);
        chk("one_tag1", int'(alloc_tag[7:4]), 0);
        cyc(2'b11, 0, 6, 2'b00, 0, 0, 0);
        chk("rd0_gnt", int'(alloc_gnt), 3);
        chk("rd0_tag0", int'(alloc_tag[3:0]), 0);
        chk("rd0_wen", int'(tf_wr_en), 2);
        chk("rd0_tag1", int'(alloc_tag[7:4]), 15);

        cyc(2'b01, 9, 0, 2'b01, 7, 0, 0);
        chk("nobypass_gnt", int'(alloc_gnt), 0);
        cyc(2'b01, 9, 0, 2'b00, 0, 0, 0);
        chk("ret7_gnt", int'(alloc_gnt), 1);
        chk("ret7_tag", int'(alloc_tag[3:0]), 7);

        cyc(2'b00, 0, 0, 2'b00, 0, 0, 1);
        for (int c = 0; c < 3; c++) begin
            cyc(2'b11, 1, 2, 2'b00, 0, 0, 0);
            chk("pre_flush_tag0", int'(alloc_tag[3:0]), 2 * c);
        end
        cyc(2'b11, 1, 2, 2'b11, 4, 5, 1);
        chk("flush_gnt", int'(alloc_gnt), 0);
        chk("flush_wen", int'(tf_wr_en), 0);
        cyc(2'b11, 2, 3, 2'b00, 0, 0, 0);
        chk("post_flush_count", int'(free_count), 16);
        chk("post_flush_tag0", int'(alloc_tag[3:0]), 0);
        chk("post_flush_tag1", int'(alloc_tag[7:4]), 1);

        cyc(2'b00, 0, 0, 2'b11, 0, 1, 0);
        cyc(2'b00, 0, 0, 2'b01, 9, 0, 0);
        chk("ovf_pre_count", int'(free_count), 16);
        chk("ovf_pre_err", int'(err), 0);
        cyc(2'b00, 0, 0, 2'b00, 0, 0, 0);
        chk("ovf_err", int'(err), 1);
        chk("ovf_count", int'(free_count), 16);
        cyc(2'b00, 0, 0, 2'b00, 0, 0, 1);
        cyc(2'b00, 0, 0, 2'b00, 0, 0, 0);
        chk("ovf_sticky", int'(err), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("rst_clears_err", int'(err), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int n = 0; n < 1500; n++) begin
            @(posedge clk);
            #1 rnd_drive();
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        alloc_req = 2'b11;
        alloc_rd = {5'd4, 5'd2};
        ret_valid = 2'b00;
        #2 rst = 1'b1;
        #1;
        chk("async_gnt", int'(alloc_gnt), 0);
        chk("async_wen", int'(tf_wr_en), 0);
        chk("async_count", int'(free_count), 16);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk);
            #1 rnd_drive();
        end
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
